srrc_tx_polyphase_flt: RTL and testbench

//  Transmit-side SRRC pulse-shaping interpolator: takes one 18-bit symbol per sym_clk_en and

---
 rtl/srrc_tx_polyphase_flt.sv | 132 +++++++++++++
 tb/tb_srrc_tx_polyphase_flt.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/srrc_tx_polyphase_flt.sv
// Polyphase SRRC transmit interpolator: one symbol in per sym_clk_en, UPSAMPLE shaped samples out.
// Define SRRC_TX_SAT_EN to clamp out on overflow; by default the output wraps.
module srrc_tx_polyphase_flt #(
  parameter int UPSAMPLE       = 4,
  parameter int TAPS_PER_PHASE = 25
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic                        sam_clk_en,
  input  logic                        sym_clk_en,
  input  logic [17:0]                 in,
  output logic [17:0]                 out,
  output logic [$clog2(UPSAMPLE)-1:0] phase
);

  localparam int NUM_TAPS = UPSAMPLE * TAPS_PER_PHASE;
  localparam int GROUPS   = (TAPS_PER_PHASE + 3) / 4;

  // Unit-energy-ish SRRC, beta 0.25, 4 samples/symbol, s0.17, symmetric about 49.5.
  localparam int COEF_TAB [NUM_TAPS] = '{
    35, 207, 204, 8, -224, -282, -95, 192,
    331, 186, -130, -339, -240, 97, 368, 299,
    -92, -471, -462, 2, 568, 725, 259, -505,
    -922, -574, 307, 961, 737, -262, -1138, -913,
    506, 1985, 1922, -317, -3430, -4718, -2087, 3807,
    9078, 8752, 517, -12300, -21108, -16169, 7256, 44879,
    83876, 108633,
    108633, 83876, 44879, 7256, -16169, -21108, -12300, 517,
    8752, 9078, 3807, -2087, -4718, -3430, -317, 1922,
    1985, 506, -913, -1138, -262, 737, 961, 307,
    -574, -922, -505, 259, 725, 568, 2, -462,
    -471, -92, 299, 368, 97, -240, -339, -130,
    186, 331, 192, -95, -282, -224, 8, 204,
    207, 35
  };

  logic signed [17:0] x_q      [TAPS_PER_PHASE];
  logic signed [35:0] prod_q   [TAPS_PER_PHASE];
  logic signed [39:0] part_q   [GROUPS];
  logic signed [39:0] acc_q;
  logic [2:0]         en_q;

  logic signed [17:0] coef_sel [TAPS_PER_PHASE];
  logic signed [39:0] part_c   [GROUPS];
  logic signed [39:0] acc_c;
  logic [17:0]        out_c;

  always_comb begin
    for (int k = 0; k < TAPS_PER_PHASE; k++) begin
      coef_sel[k] = 18'(COEF_TAB[UPSAMPLE * k + int'(phase)]);
    end
  end

  // NOTE: every always_comb output gets a default before any conditional
  // update, so the adder trees can never infer a latch.
  always_comb begin
    for (int g = 0; g < GROUPS; g++) begin
      part_c[g] = '0;
    end
    for (int k = 0; k < TAPS_PER_PHASE; k++) begin
      part_c[k / 4] = part_c[k / 4] + 40'(prod_q[k]);
    end
    acc_c = '0;
    for (int g = 0; g < GROUPS; g++) begin
      acc_c = acc_c + part_q[g];
    end
  end

`ifdef SRRC_TX_SAT_EN
  localparam logic signed [39:0] ACC_MAX = 40'sd17179738112;   // 131071 * 2^17
  localparam logic signed [39:0] ACC_MIN = -40'sd17179869184;  // -131072 * 2^17

  always_comb begin
    if (acc_q > ACC_MAX) begin
      out_c = 18'h1FFFF;
    end else if (acc_q < ACC_MIN) begin
      out_c = 18'h20000;
    end else begin
      out_c = acc_q[34:17];
    end
  end
`else
  assign out_c = acc_q[34:17];
`endif

  // NOTE: the delay line and pipeline are flop arrays, not RAM, so they take
  // the async reset; this is what lets a reset discard all in-flight data.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out   <= '0;
      phase <= '0;
      en_q  <= '0;
      acc_q <= '0;
      for (int k = 0; k < TAPS_PER_PHASE; k++) begin
        x_q[k]    <= '0;
        prod_q[k] <= '0;
      end
      for (int g = 0; g < GROUPS; g++) begin
        part_q[g] <= '0;
      end
    end else begin
      // NOTE: sequential state uses non-blocking assignments only, so the
      // shift and pipeline stages all see pre-edge values.
      en_q <= {en_q[1:0], sam_clk_en};

      // A lone sym_clk_en is a protocol violation and is ignored.
      if (sam_clk_en) begin
        out   <= out_c;
        phase <= sym_clk_en ? '0 : phase + 1'b1;
        if (sym_clk_en) begin
          x_q[0] <= in;
          for (int k = 1; k < TAPS_PER_PHASE; k++) begin
            x_q[k] <= x_q[k-1];
          end
        end
      end

      if (en_q[0]) begin
        for (int k = 0; k < TAPS_PER_PHASE; k++) begin
          prod_q[k] <= x_q[k] * coef_sel[k];
        end
      end
      if (en_q[1]) begin
        part_q <= part_c;
      end
      if (en_q[2]) begin
        acc_q <= acc_c;
      end
    end
  end

endmodule

// File: tb/tb_srrc_tx_polyphase_flt.sv
// Scoreboard bench for srrc_tx_polyphase_flt: a convolution model pushes expected samples,
// a monitor pops them on every sample strobe. Honours SRRC_TX_SAT_EN like the design.
module tb_srrc_tx_polyphase_flt;

  localparam int UP  = 4;
  localparam int TPP = 25;
  localparam int NT  = UP * TPP;

  logic        clk        = 1'b0;
  logic        reset_n    = 1'b1;
  logic        sam_clk_en = 1'b0;
  logic        sym_clk_en = 1'b0;
  logic [17:0] in_sym     = '0;
  logic [17:0] out_s;
  logic [1:0]  phase_s;

  always #5 clk = ~clk;

  srrc_tx_polyphase_flt #(.UPSAMPLE(UP), .TAPS_PER_PHASE(TPP)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .sam_clk_en (sam_clk_en),
    .sym_clk_en (sym_clk_en),
    .in         (in_sym),
    .out        (out_s),
    .phase      (phase_s)
  );

  int coef [NT] = '{
    35, 207, 204, 8, -224, -282, -95, 192, 331, 186, -130, -339, -240, 97, 368, 299,
    -92, -471, -462, 2, 568, 725, 259, -505, -922, -574, 307, 961, 737, -262, -1138, -913,
    506, 1985, 1922, -317, -3430, -4718, -2087, 3807, 9078, 8752, 517, -12300, -21108, -16169,
    7256, 44879, 83876, 108633, 108633, 83876, 44879, 7256, -16169, -21108, -12300, 517,
    8752, 9078, 3807, -2087, -4718, -3430, -317, 1922, 1985, 506, -913, -1138, -262, 737,
    961, 307, -574, -922, -505, 259, 725, 568, 2, -462, -471, -92, 299, 368, 97, -240,
    -339, -130, 186, 331, 192, -95, -282, -224, 8, 204, 207, 35
  };

  typedef struct {
    int exp_out;
    int exp_phase;
    int tag;
  } exp_t;

  exp_t sb_q[$];
  int   n_vec  = 0;
  int   n_miss = 0;
  int   test_id = 0;

  // Reference model: symbol history (newest first), sample phase, pending output.
  int m_x [TPP];
  int m_phase;
  int m_next;

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic int shape(input longint acc);
    longint q;
`ifdef SRRC_TX_SAT_EN
    if (acc > 64'sd131071 * 64'sd131072) return 131071;
    if (acc < -64'sd131072 * 64'sd131072) return -131072;
`endif
    q = acc >>> 17;
    q = q & 64'sh3FFFF;
    if (q >= 131072) q = q - 262144;
    return int'(q);
  endfunction

  task automatic model_reset();
    for (int k = 0; k < TPP; k++) m_x[k] = 0;
    m_phase = 0;
    m_next  = 0;
  endtask

  task automatic model_step(input bit sym, input int din, output exp_t e);
    longint acc;
    e.exp_out = m_next;
    if (sym) begin
      for (int k = TPP - 1; k > 0; k--) m_x[k] = m_x[k-1];
      m_x[0]  = din;
      m_phase = 0;
    end else begin
      m_phase = (m_phase + 1) % UP;
    end
    e.exp_phase = m_phase;
    e.tag       = test_id;
    acc = 0;
    for (int k = 0; k < TPP; k++) acc += longint'(m_x[k]) * longint'(coef[m_phase + UP * k]);
    m_next = shape(acc);
  endtask

  // Entered just after a negedge; issues one sample strobe then idles to a gap-cycle spacing.
  task automatic strobe(input bit sym, input logic [17:0] din, input int gap,
                        input bit direct, input int direct_out);
    exp_t e;
    sam_clk_en = 1'b1;
    sym_clk_en = sym;
    in_sym     = din;
    model_step(sym, int'($signed(din)), e);
    if (direct) e.exp_out = direct_out;
    sb_q.push_back(e);
    @(negedge clk);
    sam_clk_en = 1'b0;
    sym_clk_en = 1'b0;
    in_sym     = 18'($urandom());
    repeat (gap - 1) @(negedge clk);
  endtask

  task automatic send_symbol(input logic [17:0] din);
    for (int s = 0; s < UP; s++) begin
      strobe(s == 0, (s == 0) ? din : 18'($urandom()), int'($urandom_range(6, 4)), 1'b0, 0);
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      if (reset_n && sam_clk_en) begin
        @(negedge clk);
        if (sb_q.size() == 0) begin
          n_vec++;
          n_miss++;
          $display("FAIL sb_underflow: sample strobe with no expected entry, out=%0d", int'($signed(out_s)));
        end else begin
          e = sb_q.pop_front();
          check($sformatf("t%0d_out", e.tag), int'($signed(out_s)), e.exp_out);
          check($sformatf("t%0d_phase", e.tag), int'(phase_s), e.exp_phase);
        end
      end
    end
  end

  initial begin : watchdog
    #5000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin : stim
    int v;
    logic [17:0] sv;
    model_reset();

    // 1: reset with random strobes and data
    test_id = 1;
    #1 reset_n = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      sam_clk_en = ($urandom() & 1) != 0;
      sym_clk_en = ($urandom() & 1) != 0;
      in_sym     = 18'($urandom());
      #1;
      if (i % 4 == 3) begin
        check("reset_out", int'($signed(out_s)), 0);
        check("reset_phase", int'(phase_s), 0);
      end
    end
    @(negedge clk);
    sam_clk_en = 1'b0;
    sym_clk_en = 1'b0;
    reset_n    = 1'b1;
    repeat (20) @(negedge clk);
    check("post_release_out", int'($signed(out_s)), 0);
    check("post_release_phase", int'(phase_s), 0);

    // 2: impulse of 0.5 -> coefficient sequence halved, then zero
    test_id = 2;
    for (int s = 0; s < NT + 4; s++) begin
      v = (s == 0 || s > NT) ? 0 : (coef[s-1] >>> 1);
      strobe(s % UP == 0, (s == 0) ? 18'h10000 : 18'h0, 4, 1'b1, v);
    end

    // 3: phase sequence, dropped symbol strobe, lone symbol strobe
    test_id = 3;
    for (int i = 0; i < 3; i++) send_symbol(18'($urandom()));
    for (int s = 0; s < UP; s++) strobe(1'b0, 18'($urandom()), 4, 1'b0, 0);
    sym_clk_en = 1'b1;
    in_sym     = 18'($urandom());
    @(negedge clk);
    sym_clk_en = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 2; i++) send_symbol(18'($urandom()));

    // 4: random symbols against the model
    test_id = 4;
    for (int i = 0; i < 2000; i++) send_symbol(18'($urandom()));

    // 5: worst-case positive then negative accumulation at phase 0
    test_id = 5;
    for (int pol = 1; pol >= -1; pol -= 2) begin
      for (int i = 0; i < TPP; i++) begin
        v  = (coef[UP * (TPP - 1 - i)] > 0) ? 131071 : -131071;
        sv = 18'(pol * v);
        send_symbol(sv);
      end
      send_symbol(18'h0);
    end

    // 6: mid-stream reset during symbol 10, then a clean restart
    test_id = 6;
    for (int i = 0; i < 10; i++) send_symbol(18'($urandom()));
    strobe(1'b1, 18'($urandom()), 4, 1'b0, 0);
    reset_n = 1'b0;
    #1;
    check("midrst_out", int'($signed(out_s)), 0);
    check("midrst_phase", int'(phase_s), 0);
    @(negedge clk);
    reset_n = 1'b1;
    sb_q.delete();
    model_reset();
    @(negedge clk);
    for (int i = 0; i < TPP; i++) send_symbol(18'($urandom()));

    repeat (10) @(negedge clk);
    check("sb_drained", sb_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
